// File: rtl/vga_plot_arbiter_pkg.sv
// vga_pkg: shared definitions for the VGA pixel-write path.
//   XW/YW/CW    : x, y and colour field widths of the VGA adapter
//   XMAX/YMAX   : last valid column/row of the 160x120 frame
//   colour_e    : named 3-bit colours ({R,G,B} bit order)
//   arb_state_e : arbiter FSM states
//   idx_width() : width of an index into an n-entry vector (at least 1)
package vga_pkg;

    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int XMAX = 159;
    localparam int YMAX = 119;

    typedef enum logic [CW-1:0] {
        BLACK   = 3'b000,
        BLUE    = 3'b001,
        GREEN   = 3'b010,
        CYAN    = 3'b011,
        RED     = 3'b100,
        MAGENTA = 3'b101,
        YELLOW  = 3'b110,
        WHITE   = 3'b111
    } colour_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: bundle between the pixel engines and the VGA adapter.
//   req/req_x/req_y/req_colour : per-engine request and packed pixel fields
//   gnt                        : one-hot grant back to the engines
//   vga_x/vga_y/vga_colour/vga_plot : registered pixel write port
//   busy/owner                 : arbiter status
// Modports: master = engine/adapter side, slave = arbiter side.
interface vga_plot_arbiter_if #(
    parameter int NREQ = 2
);
    import vga_pkg::*;

    localparam int OW = idx_width(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*YW-1:0] req_y;
    logic [NREQ*CW-1:0] req_colour;
    logic [NREQ-1:0]    gnt;
    logic [XW-1:0]      vga_x;
    logic [YW-1:0]      vga_y;
    logic [CW-1:0]      vga_colour;
    logic               vga_plot;
    logic               busy;
    logic [OW-1:0]      owner;

    modport master (
        output req, req_x, req_y, req_colour,
        input  gnt, vga_x, vga_y, vga_colour, vga_plot, busy, owner
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, owner
    );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// vga_rr_pick: combinational rotating-priority encoder.
//   req   in  N   request vector
//   start in  IW  index searched first; search continues start+1, ... mod N
//   idx   out IW  first requesting index found (0 when none)
//   found out 1   any request present
module vga_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin : search
        logic [IW-1:0] p;
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned (which would infer a latch); blocking '=' is correct
        // here because later loop iterations must see the updated 'found'.
        idx   = '0;
        found = 1'b0;
        p     = '0;
        for (int i = 0; i < N; i++) begin
            p = IW'((int'(start) + i) % N);
            if (!found && req[p]) begin
                found = 1'b1;
                idx   = p;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single VGA pixel-write port between NREQ
// pixel engines with round-robin arbitration and bounded bursts.
//   CLOCK_50 in : system clock, rising edge
//   Reset    in : synchronous, active-high
//   bus         : vga_plot_arbiter_if.slave (requests, grant, pixel port,
//                 busy, owner)
// Parameters: NREQ (2..8 engines), MAX_BURST (pixels per grant, 0 = unlimited).
// Optional feature: define VGA_PLOT_CLIP_EN to suppress the write strobe for
// beats whose x > XMAX or y > YMAX (the beat is still accepted and counted).
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16
) (
    input logic              CLOCK_50,
    input logic              Reset,
    vga_plot_arbiter_if.slave bus
);

    localparam int OW = idx_width(NREQ);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_e    state;
    logic [OW-1:0] owner;
    logic [BW-1:0] beat_cnt;

    logic [OW-1:0] start;
    logic [OW-1:0] pick_idx;
    logic          pick_found;
    logic          xfer;
    logic          last_beat;
    logic          plot_ok;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [CW-1:0] sel_colour;

    // The last grantee gets lowest priority in the next arbitration.
    assign start = OW'((int'(owner) + 1) % NREQ);

    vga_rr_pick #(
        .N  (NREQ),
        .IW (OW)
    ) u_pick (
        .req   (bus.req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        bus.gnt = '0;
        if (state == GRANT)
            bus.gnt[owner] = bus.req[owner];
    end

    assign xfer       = (state == GRANT) && bus.req[owner];
    assign last_beat  = (MAX_BURST != 0) && (beat_cnt == BW'(MAX_BURST - 1));
    assign sel_x      = bus.req_x[int'(owner)*XW +: XW];
    assign sel_y      = bus.req_y[int'(owner)*YW +: YW];
    assign sel_colour = bus.req_colour[int'(owner)*CW +: CW];

`ifdef VGA_PLOT_CLIP_EN
    assign plot_ok = (int'(sel_x) <= XMAX) && (int'(sel_y) <= YMAX);
`else
    assign plot_ok = 1'b1;
`endif

    assign bus.owner = owner;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state          <= IDLE;
            owner          <= OW'(NREQ - 1);
            beat_cnt       <= '0;
            bus.busy       <= 1'b0;
            bus.vga_plot   <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
        end else begin
            // Pixel port: coordinates hold between transfers, strobe does not.
            bus.vga_plot <= xfer && plot_ok;
            if (xfer) begin
                bus.vga_x      <= sel_x;
                bus.vga_y      <= sel_y;
                bus.vga_colour <= sel_colour;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                        bus.busy <= 1'b1;
                    end
                end
                GRANT: begin
                    if (xfer && MAX_BURST != 0)
                        beat_cnt <= beat_cnt + 1'b1;
                    // The final beat is plotted above; the grant ends after it.
                    if (!bus.req[owner] || (xfer && last_beat)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed self-checking bench for vga_plot_arbiter
// (NREQ=2, MAX_BURST=4). Expected values are hand-computed per step.
module tb_vga_plot_arbiter;
    import vga_pkg::*;

    logic CLOCK_50;
    logic Reset;

    int n_tests;
    int n_fail;

    vga_plot_arbiter_if #(.NREQ(2)) bus ();

    vga_plot_arbiter #(
        .NREQ      (2),
        .MAX_BURST (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Expected vga_plot / vga_x per edge for the continuous two-engine burst.
    logic [12:1] exp_plot2;
    int          exp_x2 [1:12];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic set_eng(input int e, input int x, input int y, input int c);
        bus.req_x[e*XW +: XW]      = XW'(x);
        bus.req_y[e*YW +: YW]      = YW'(y);
        bus.req_colour[e*CW +: CW] = CW'(c);
    endtask

    task automatic check_pixel(input string tag, input int p, input int x, input int y, input int c);
        check({tag, ".plot"},   32'(bus.vga_plot),   32'(p));
        check({tag, ".x"},      32'(bus.vga_x),      32'(x));
        check({tag, ".y"},      32'(bus.vga_y),      32'(y));
        check({tag, ".colour"}, 32'(bus.vga_colour), 32'(c));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        bus.req    = '0;
        bus.req_x  = '0;
        bus.req_y  = '0;
        bus.req_colour = '0;

        exp_plot2 = 12'b1011_1101_1110;  // bit k = edge k
        for (int k = 1; k <= 12; k++)
            exp_x2[k] = (k >= 7 && k <= 10) ? 3 : 1;

        // ---- Reset state
        tick();
        tick();
        check("rst.gnt",   32'(bus.gnt),   0);
        check("rst.busy",  32'(bus.busy),  0);
        check("rst.owner", 32'(bus.owner), 1);
        check_pixel("rst", 0, 0, 0, 0);

        // ---- Test 1: single engine, three beats
        Reset = 1'b0;
        set_eng(0, 10, 20, MAGENTA);
        bus.req = 2'b01;
        #1 check("t1.c0.gnt", 32'(bus.gnt), 0);
        tick();                                   // edge 1
        check("t1.c1.gnt",   32'(bus.gnt),      32'b01);
        check("t1.c1.busy",  32'(bus.busy),     1);
        check("t1.c1.owner", 32'(bus.owner),    0);
        check("t1.c1.plot",  32'(bus.vga_plot), 0);
        tick();                                   // edge 2
        check_pixel("t1.c2", 1, 10, 20, 5);
        tick();                                   // edge 3
        check_pixel("t1.c3", 1, 10, 20, 5);
        tick();                                   // edge 4
        check_pixel("t1.c4", 1, 10, 20, 5);
        bus.req = 2'b00;
        #1 check("t1.drop.gnt", 32'(bus.gnt), 0);
        tick();                                   // edge 5: release
        check_pixel("t1.c5", 0, 10, 20, 5);
        check("t1.c5.busy", 32'(bus.busy), 0);

        // ---- Test 2: both engines continuously, MAX_BURST=4
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        set_eng(0, 1, 2, BLUE);
        set_eng(1, 3, 4, GREEN);
        bus.req = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t2.e%0d.plot", k), 32'(bus.vga_plot), 32'(exp_plot2[k]));
            if (exp_plot2[k])
                check($sformatf("t2.e%0d.x", k), 32'(bus.vga_x), 32'(exp_x2[k]));
            if (k == 6)
                check("t2.e6.owner", 32'(bus.owner), 1);
            if (k == 11)
                check("t2.e11.gnt", 32'(bus.gnt), 32'b01);
        end
        bus.req = 2'b00;
        tick();
        check("t2.end.busy", 32'(bus.busy), 0);

        // ---- Test 3: engine 0 drops after two pixels, engine 1 waiting
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.req = 2'b11;
        tick();                                   // edge 1
        check("t3.e1.gnt", 32'(bus.gnt), 32'b01);
        tick();                                   // edge 2
        check_pixel("t3.e2", 1, 1, 2, 1);
        tick();                                   // edge 3
        check_pixel("t3.e3", 1, 1, 2, 1);
        bus.req = 2'b10;
        #1 check("t3.drop.gnt", 32'(bus.gnt), 0);
        tick();                                   // edge 4: bubble
        check("t3.e4.plot", 32'(bus.vga_plot), 0);
        check("t3.e4.gnt",  32'(bus.gnt),      0);
        check("t3.e4.busy", 32'(bus.busy),     0);
        tick();                                   // edge 5
        check("t3.e5.gnt",   32'(bus.gnt),      32'b10);
        check("t3.e5.owner", 32'(bus.owner),    1);
        check("t3.e5.plot",  32'(bus.vga_plot), 0);
        tick();                                   // edge 6
        check_pixel("t3.e6", 1, 3, 4, 2);
        bus.req = 2'b00;
        tick();
        tick();

        // ---- Test 4: reset during the third beat
        set_eng(0, 10, 20, MAGENTA);
        bus.req = 2'b01;
        tick();                                   // edge 1
        tick();                                   // edge 2
        tick();                                   // edge 3
        check("t4.e3.gnt", 32'(bus.gnt), 32'b01);
        Reset = 1'b1;
        tick();                                   // edge 4
        check("t4.gnt",   32'(bus.gnt),   0);
        check("t4.busy",  32'(bus.busy),  0);
        check("t4.owner", 32'(bus.owner), 1);
        check_pixel("t4", 0, 0, 0, 0);

        // ---- Test 5: off-screen beat then corner beat
        Reset = 1'b0;
        set_eng(0, 160, 5, WHITE);
        bus.req = 2'b01;
        tick();                                   // edge 1
        check("t5.e1.gnt", 32'(bus.gnt), 32'b01);
        tick();                                   // edge 2
`ifdef VGA_PLOT_CLIP_EN
        check_pixel("t5.off", 0, 160, 5, 7);
`else
        check_pixel("t5.off", 1, 160, 5, 7);
`endif
        bus.req = 2'b00;
        tick();                                   // edge 3: release
        set_eng(0, 159, 119, YELLOW);
        bus.req = 2'b01;
        tick();                                   // edge 4
        check("t5.e4.gnt", 32'(bus.gnt), 32'b01);
        tick();                                   // edge 5
        check_pixel("t5.corner", 1, 159, 119, 6);
        bus.req = 2'b00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
Shares the single VGA pixel-write port (vga_x/vga_y/vga_colour/vga_plot) between NREQ pixel engines, e.g. the screen-clear engine and the circle engine.
- Per-requester req/gnt handshake.
- Round-robin arbitration with bounded bursts.
- Registered pixel outputs that drive the VGA adapter directly.
- Replaces ad-hoc muxing on a Done flag, so later engines (line, fill) attach without top-level rework.

Parameters:
NREQ, 2, number of requesting engines (2..8)
XW, 8, x coordinate width
YW, 7, y coordinate width
CW, 3, colour width
MAX_BURST, 16, max pixels per grant; 0 = unlimited
XMAX, 159, last valid column
YMAX, 119, last valid row

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
req  in  NREQ  per-engine pixel request; pixel fields valid while high
req_x  in  NREQ*XW  packed x, engine i at [i*XW +: XW]
req_y  in  NREQ*YW  packed y
req_colour  in  NREQ*CW  packed colour
gnt  out  NREQ  one-hot grant, combinational; a beat transfers in any cycle with req[i]&gnt[i]
vga_x  out  XW  registered pixel x
vga_y  out  YW  registered pixel y
vga_colour  out  CW  registered colour
vga_plot  out  1  registered write strobe
busy  out  1  high in GRANT state
owner  out  max(1,$clog2(NREQ))  current or last grantee index

Behaviour:
- States: IDLE, GRANT.
- Reset (sampled at CLOCK_50 edge, overrides everything, including mid-burst):
  - state=IDLE, gnt=0, vga_plot=0, vga_x/vga_y/vga_colour=0.
  - owner=NREQ-1, so engine 0 wins the first arbitration.
  - beat counter=0.
- IDLE:
  - gnt=0.
  - If any req: pick the first set req searching owner+1, owner+2, ... mod NREQ.
  - Load owner, clear beat counter, go to GRANT next edge.
  - With no req, stay in IDLE.
- GRANT:
  - gnt[owner]=req[owner]; all other gnt bits 0.
  - Each transfer cycle: the next edge registers that engine's x/y/colour with vga_plot=1, and the beat counter increments.
- GRANT release: go to IDLE next edge when either
  - req[owner]=0, or
  - a transfer occurs with beat count = MAX_BURST-1 (MAX_BURST≠0).
  The final beat is still plotted. A still-requesting owner re-arbitrates at lowest priority.
- Latency:
  - req rises in IDLE at cycle 0 → gnt at cycle 1 → vga_plot at cycle 2.
  - Steady burst: one pixel per clock.
  - Owner switch costs one IDLE bubble.
- Non-transfer cycles: vga_plot=0 next edge; vga_x/vga_y/vga_colour hold their last value.
- Engine obligations: fields held stable while req is high; an engine may drop req between pixels.
- Beat counter: width $clog2(MAX_BURST+1); it never wraps because release occurs first.
- NREQ=1: always grants engine 0; the bubble still occurs after each release.

Optional Feature:
Macro VGA_PLOT_CLIP_EN.
- Defined: a beat with x>XMAX or y>YMAX is still accepted (gnt, counted toward the burst) but produces vga_plot=0 that cycle. vga_x/vga_y/vga_colour still update.
- Undefined: every transfer produces vga_plot=1 with the coordinates passed through unchanged.

Decomposition:
- Package vga_pkg holds:
  - XW, YW, CW, XMAX, YMAX.
  - Colour constants (BLACK=3'b000 .. WHITE=3'b111).
  - State enum {IDLE, GRANT}.
- One sub-module, vga_rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector and start pointer.
  - Outputs: index and found flag.
  - Reusable by later schedulers.

Test Plan:
1. Reset, then req=2'b01 with engine 0 at (10,20,3'b101) held 3 cycles → gnt=01 from cycle 1; vga_plot=1 with (10,20,5) on cycles 2–4; busy rises cycle 1.
2. req=2'b11 continuously, MAX_BURST=4 → 4 pixels from engine 0, one bubble (vga_plot=0), 4 pixels from engine 1, then engine 0 again.
3. Engine 0 drops req after 2 pixels while engine 1 requests → engine 0 releases after 2 beats; gnt=10 follows one bubble cycle later.
4. Reset asserted mid-burst on the 3rd beat → next edge gnt=0, vga_plot=0, outputs 0, busy=0, owner=NREQ-1.
5. VGA_PLOT_CLIP_EN defined, beats at (160,5) then (159,119) → first beat is granted with vga_plot=0; second beat gives vga_plot=1. With the macro undefined, both beats give vga_plot=1.
